// File: rtl/psram_cmd_scheduler.sv
// Queues parsed UART commands and issues them one at a time to the PSRAM controller
// after the power-up wait; read results are handed to the UART transmitter.
module psram_cmd_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 16,
  parameter int INIT_CYCLES    = 4050,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cmd_valid,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  cmd_full,
  output logic                  ready,
  output logic                  psram_start,
  output logic                  psram_write,
  output logic [ADDR_WIDTH-1:0] psram_addr,
  output logic [DATA_WIDTH-1:0] psram_wdata,
  input  logic                  psram_done,
  input  logic [DATA_WIDTH-1:0] psram_rdata,
  output logic                  tx_send,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_busy,
  output logic                  error,
  output logic [7:0]            drop_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int INIT_W  = $clog2(INIT_CYCLES + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_ISSUE, ST_WAIT_DONE, ST_TX_WAIT, ST_SEND, ST_TX_ACK
  } state_t;

  state_t state, state_next;

  logic                  fifo_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic [INIT_W-1:0]     init_cnt;
  logic [TIMER_W-1:0]    timer;

  logic push, pop, reject, fifo_empty;
  logic init_done, capture_rdata, timeout_err;

  // A full queue rejects even when the FSM pops in the same cycle.
  assign cmd_full   = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid && !cmd_full;
  assign reject     = cmd_valid && cmd_full;

  assign psram_start = (state == ST_ISSUE);
  assign tx_send     = (state == ST_SEND);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + (PTR_W+1)'(1);
      else if (!push && pop) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_wdata[wr_ptr] <= cmd_wdata;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_INIT;
    else         state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pop           = 1'b0;
    init_done     = 1'b0;
    capture_rdata = 1'b0;
    timeout_err   = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
          init_done  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT_DONE;
      // A done arriving in the timeout cycle still completes the op.
      ST_WAIT_DONE: begin
        if (psram_done) begin
          if (psram_write) begin
            state_next = ST_IDLE;
          end else begin
            capture_rdata = 1'b1;
            state_next    = ST_TX_WAIT;
          end
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      ST_TX_WAIT: begin
        if (!tx_busy) state_next = ST_SEND;
      end
      ST_SEND: state_next = ST_TX_ACK;
      ST_TX_ACK: begin
        if (tx_busy) begin
          state_next = ST_IDLE;
        end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_err = 1'b1;
          state_next  = ST_IDLE;
        end
      end
      default: state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      init_cnt <= '0;
      timer    <= '0;
    end else begin
      if (state == ST_INIT) init_cnt <= init_cnt + INIT_W'(1);
      if (state == ST_ISSUE || state == ST_SEND)
        timer <= '0;
      else if (state == ST_WAIT_DONE || state == ST_TX_ACK)
        timer <= timer + TIMER_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      ready       <= 1'b0;
      psram_write <= 1'b0;
      psram_addr  <= '0;
      psram_wdata <= '0;
      tx_data     <= '0;
      error       <= 1'b0;
      drop_count  <= '0;
    end else begin
      if (init_done) ready <= 1'b1;
      if (pop) begin
        psram_write <= fifo_write[rd_ptr];
        psram_addr  <= fifo_addr[rd_ptr];
        psram_wdata <= fifo_wdata[rd_ptr];
      end
      if (capture_rdata) tx_data <= psram_rdata;
      if (reject || timeout_err) error <= 1'b1;
      if (reject && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_psram_cmd_scheduler.sv
// Directed bench for psram_cmd_scheduler: init wait, write/read flow, overflow,
// PSRAM timeout and reset in the middle of a read.
module tb_psram_cmd_scheduler;

  localparam int INIT_CYCLES    = 4050;
  localparam int TIMEOUT_CYCLES = 1024;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [22:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        cmd_full, ready, psram_start, psram_write;
  logic [22:0] psram_addr;
  logic [15:0] psram_wdata;
  logic        psram_done = 1'b0;
  logic [15:0] psram_rdata = '0;
  logic        tx_send;
  logic [15:0] tx_data;
  logic        tx_busy = 1'b0;
  logic        error;
  logic [7:0]  drop_count;

  int tests_run = 0;
  int tests_failed = 0;

  psram_cmd_scheduler #(
    .FIFO_DEPTH(4), .ADDR_WIDTH(23), .DATA_WIDTH(16),
    .INIT_CYCLES(INIT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_full(cmd_full), .ready(ready),
    .psram_start(psram_start), .psram_write(psram_write), .psram_addr(psram_addr),
    .psram_wdata(psram_wdata), .psram_done(psram_done), .psram_rdata(psram_rdata),
    .tx_send(tx_send), .tx_data(tx_data), .tx_busy(tx_busy),
    .error(error), .drop_count(drop_count)
  );

  always #5 sys_clk = ~sys_clk;

  // Inputs change and outputs are sampled 1 ns after each rising edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [22:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_done(input logic [15:0] rd);
    psram_done  = 1'b1;
    psram_rdata = rd;
    tick();
    psram_done = 1'b0;
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (psram_start) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit early_start;
    sys_rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if ({ready, psram_start, tx_send, error, cmd_full} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected 00000", {ready, psram_start, tx_send, error, cmd_full});
    end
    tests_run++;
    if ({drop_count, tx_data, psram_addr, psram_wdata, psram_write} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got drop=%h tx=%h addr=%h wd=%h w=%b expected all 0",
               drop_count, tx_data, psram_addr, psram_wdata, psram_write);
    end
    sys_rst = 1'b0;
    early_start = 1'b0;
    for (int i = 0; i < INIT_CYCLES - 1; i++) begin
      tick();
      if (psram_start) early_start = 1'b1;
    end
    tests_run++;
    if (ready !== 1'b0 || early_start) begin
      tests_failed++;
      $display("[TB] FAIL init_hold: got ready=%b start_seen=%b expected 0 0", ready, early_start);
    end
    tick();
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL init_ready: got %b expected 1", ready);
    end
  endtask

  task automatic test_write();
    bit sent;
    push(1'b1, 23'h001234, 16'hBEEF);
    tests_run++;
    if (psram_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_n1: got start=%b expected 0", psram_start);
    end
    tick();
    tests_run++;
    if ({psram_start, psram_write, psram_addr, psram_wdata} !== {1'b1, 1'b1, 23'h001234, 16'hBEEF}) begin
      tests_failed++;
      $display("[TB] FAIL write_issue: got start=%b w=%b addr=%h wd=%h expected 1 1 001234 beef",
               psram_start, psram_write, psram_addr, psram_wdata);
    end
    tick();
    tests_run++;
    if (psram_start !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_single: got start=%b expected 0", psram_start);
    end
    pulse_done(16'h0000);
    sent = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tx_send || psram_start) sent = 1'b1;
      tick();
    end
    tests_run++;
    if (sent !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL write_no_tx: got activity=%b expected 0", sent);
    end
  endtask

  task automatic test_read();
    tx_busy = 1'b1;
    push(1'b0, 23'h7FFFFF, 16'h0000);
    tick();
    tests_run++;
    if ({psram_start, psram_write, psram_addr} !== {1'b1, 1'b0, 23'h7FFFFF}) begin
      tests_failed++;
      $display("[TB] FAIL read_issue: got start=%b w=%b addr=%h expected 1 0 7fffff",
               psram_start, psram_write, psram_addr);
    end
    tick();
    pulse_done(16'hA55A);
    tests_run++;
    if (tx_data !== 16'hA55A) begin
      tests_failed++;
      $display("[TB] FAIL read_data: got %h expected a55a", tx_data);
    end
    tick();
    tick();
    tests_run++;
    if (tx_send !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_wait_busy: got tx_send=%b expected 0", tx_send);
    end
    tx_busy = 1'b0;
    tick();
    tests_run++;
    if (tx_send !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL read_send: got tx_send=%b expected 1", tx_send);
    end
    tx_busy = 1'b1;
    tick();
    tests_run++;
    if (tx_send !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_send_single: got tx_send=%b expected 0", tx_send);
    end
    tick();
    tx_busy = 1'b0;
    tick();
    tests_run++;
    if (error !== 1'b0 || tx_send !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_ack: got error=%b tx_send=%b expected 0 0", error, tx_send);
    end
  endtask

  task automatic test_timeout();
    push(1'b1, 23'h000100, 16'h1111);
    push(1'b1, 23'h000200, 16'h2222);
    tests_run++;
    if (psram_start !== 1'b1 || psram_addr !== 23'h000100) begin
      tests_failed++;
      $display("[TB] FAIL timeout_issue1: got start=%b addr=%h expected 1 000100", psram_start, psram_addr);
    end
    for (int i = 0; i < TIMEOUT_CYCLES; i++) tick();
    tests_run++;
    if (error !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL timeout_early: got error=%b expected 0", error);
    end
    tick();
    tests_run++;
    if (error !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_error: got error=%b expected 1", error);
    end
    tick();
    tests_run++;
    if (psram_start !== 1'b1 || psram_addr !== 23'h000200) begin
      tests_failed++;
      $display("[TB] FAIL timeout_next: got start=%b addr=%h expected 1 000200", psram_start, psram_addr);
    end
    tick();
    pulse_done(16'h0000);
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [22:0] addrs [5];
    for (int i = 0; i < 5; i++) addrs[i] = 23'h000300 + 23'(i);
    push(1'b1, 23'h0000AA, 16'hAAAA);
    tick();
    for (int i = 0; i < 5; i++) push(1'b1, addrs[i], 16'(i));
    tests_run++;
    if ({cmd_full, error, drop_count} !== {1'b1, 1'b1, 8'd1}) begin
      tests_failed++;
      $display("[TB] FAIL overflow: got full=%b error=%b drop=%0d expected 1 1 1", cmd_full, error, drop_count);
    end
    pulse_done(16'h0000);
    for (int i = 0; i < 4; i++) begin
      wait_start(seen);
      tests_run++;
      if (!seen || psram_addr !== addrs[i]) begin
        tests_failed++;
        $display("[TB] FAIL order_%0d: got seen=%b addr=%h expected 1 %h", i, seen, psram_addr, addrs[i]);
      end
      tick();
      pulse_done(16'h0000);
    end
    wait_start(seen);
    tests_run++;
    if (seen !== 1'b0 || cmd_full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dropped_issued: got seen=%b full=%b expected 0 0", seen, cmd_full);
    end
  endtask

  task automatic test_reset_mid_read();
    bit activity;
    tx_busy = 1'b0;
    push(1'b0, 23'h000ABC, 16'h0000);
    push(1'b1, 23'h000400, 16'h4444);
    push(1'b1, 23'h000401, 16'h5555);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    tests_run++;
    if ({ready, error, cmd_full, psram_start, tx_send, psram_write} !== 6'b0 ||
        {drop_count, tx_data, psram_addr, psram_wdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs: got rdy=%b err=%b full=%b drop=%0d tx=%h addr=%h expected all 0",
               ready, error, cmd_full, drop_count, tx_data, psram_addr);
    end
    pulse_done(16'h1234);
    activity = 1'b0;
    for (int i = 0; i < INIT_CYCLES - 2; i++) begin
      if (tx_send || psram_start) activity = 1'b1;
      tick();
    end
    tests_run++;
    if (ready !== 1'b0 || activity !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_init: got ready=%b activity=%b expected 0 0", ready, activity);
    end
    tick();
    tests_run++;
    if (ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreset_ready: got %b expected 1", ready);
    end
    for (int i = 0; i < 20; i++) begin
      if (tx_send || psram_start) activity = 1'b1;
      tick();
    end
    tests_run++;
    if (activity !== 1'b0 || tx_data !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_queue_empty: got activity=%b tx=%h expected 0 0000", activity, tx_data);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
